shift_packer: RTL

SHIFT_PACKER -- requirements
Module: shift_packer

---
 rtl/shift_pkg.sv | 14 +
 rtl/shift_chunk_counter.sv | 44 ++++
 rtl/shift_packer.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/shift_pkg.sv
// Shared types and default geometry for the shift packer.
// Optional word parity output: define SHIFT_PACKER_PARITY_EN.
package shift_pkg;

  localparam int SIZE  = 64;
  localparam int CHUNK = 4;
  localparam int TAP_W = 4;

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } state_e;

endpackage

// File: rtl/shift_chunk_counter.sv
// Chunk counter: clear, load one, fill to max, saturating increment.
// Built as part of the shift packer (see SHIFT_PACKER_PARITY_EN there).
module shift_chunk_counter #(
  parameter int MAX = 16,
  parameter int CW  = $clog2(MAX + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          load_one,
  input  logic          fill,
  input  logic          inc,
  output logic [CW-1:0] count
);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  always_comb begin
    count_d = count_q;
    unique case (1'b1)
      clear:    count_d = '0;
      load_one: count_d = CW'(1);
      fill:     count_d = CW'(MAX);
      inc: begin
        if (count_q != CW'(MAX)) begin
          count_d = count_q + 1'b1;
        end
      end
      default:  count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/shift_packer.sv
// Chunk-to-word shift packer with flush padding and valid/ready output.
// Define SHIFT_PACKER_PARITY_EN to add the registered word_parity port.
module shift_packer #(
  parameter int SIZE  = shift_pkg::SIZE,
  parameter int CHUNK = shift_pkg::CHUNK,
  parameter int TAP_W = shift_pkg::TAP_W,
  parameter int CW    = $clog2(SIZE / CHUNK + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             msb_first,
  input  logic [CHUNK-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             flush,
  output logic [SIZE-1:0]  word_out,
  output logic             word_valid,
  input  logic             word_ready,
  output logic [TAP_W-1:0] tap,
  output logic [CW-1:0]    count
`ifdef SHIFT_PACKER_PARITY_EN
  ,
  output logic             word_parity
`endif
);

  import shift_pkg::*;

  localparam int N = SIZE / CHUNK;

  state_e          state_q;
  state_e          state_d;
  logic [SIZE-1:0] word_q;
  logic [SIZE-1:0] word_d;
  logic            accept;
  logic            cnt_clr;
  logic            cnt_one;
  logic            cnt_max;
  logic            cnt_inc;

  function automatic logic [SIZE-1:0] shift_in(
    input logic [SIZE-1:0]  w,
    input logic [CHUNK-1:0] d,
    input logic             msb
  );
    if (msb) begin
      return {w[SIZE-CHUNK-1:0], d};
    end
    return {d, w[SIZE-1:CHUNK]};
  endfunction

  assign in_ready = (state_q == FILL) ? 1'b1 : word_ready;
  assign accept   = in_valid & in_ready;

  always_comb begin
    int pad_n;
    pad_n   = 0;
    state_d = state_q;
    word_d  = word_q;
    cnt_clr = 1'b0;
    cnt_one = 1'b0;
    cnt_max = 1'b0;
    cnt_inc = 1'b0;
    unique case (state_q)
      FILL: begin
        if (accept) begin
          word_d = shift_in(word_q, in_data, msb_first);
        end
        // Padding follows the beat taken in the same cycle.
        if (flush && count != '0) begin
          pad_n = N - int'(count) - int'(accept);
          for (int i = 0; i < N; i++) begin
            if (i < pad_n) begin
              word_d = shift_in(word_d, '0, msb_first);
            end
          end
          state_d = FULL;
          cnt_max = 1'b1;
        end else if (accept) begin
          if (int'(count) == N - 1) begin
            state_d = FULL;
            cnt_max = 1'b1;
          end else begin
            cnt_inc = 1'b1;
          end
        end
      end
      FULL: begin
        if (word_ready) begin
          state_d = FILL;
          if (accept) begin
            word_d  = shift_in('0, in_data, msb_first);
            cnt_one = 1'b1;
          end else begin
            word_d  = '0;
            cnt_clr = 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= FILL;
      word_q  <= '0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
    end
  end

  shift_chunk_counter #(
    .MAX (N),
    .CW  (CW)
  ) u_cnt (
    .clk      (clk),
    .reset    (reset),
    .clear    (cnt_clr),
    .load_one (cnt_one),
    .fill     (cnt_max),
    .inc      (cnt_inc),
    .count    (count)
  );

  assign word_out   = word_q;
  assign word_valid = (state_q == FULL);
  assign tap        = word_q[SIZE-1 -: TAP_W];

`ifdef SHIFT_PACKER_PARITY_EN
  logic parity_q;
  logic parity_d;

  always_comb begin
    parity_d = 1'b0;
    if (state_d == FULL) begin
      parity_d = ^word_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      parity_q <= 1'b0;
    end else begin
      parity_q <= parity_d;
    end
  end

  assign word_parity = parity_q;
`endif

endmodule
